// File: rtl/if_id_queue_pkg.sv
// rtl/if_id_queue_pkg.sv - shared constants and entry type for the fetch/decode queue
package if_id_queue_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

endpackage

// File: rtl/if_id_storage.sv
// rtl/if_id_storage.sv - DEPTH-entry register array, one write port, asynchronous read port
module if_id_storage
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  entry_t                   wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output entry_t                   rdata
);

    entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '{pc: '0, instr: NOP_INSTR};
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - in-order {pc, instr} buffer between fetch and decode with flush
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_valid,
    input  logic [XLEN-1:0]          fetch_pc,
    input  logic [XLEN-1:0]          fetch_instr,
    output logic                     fetch_ready,
    input  logic                     flush,
    output logic                     id_valid,
    output logic [XLEN-1:0]          id_pc,
    output logic [XLEN-1:0]          id_pc_plus4,
    output logic [XLEN-1:0]          id_instr,
    input  logic                     id_ready,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    entry_t        head;

    // fetch_ready depends on registered count only, keeping id_ready/flush off the fetch path
    assign fetch_ready = (count < FULL_COUNT);
    assign id_valid    = (count != '0);
    assign push        = fetch_valid && fetch_ready && !flush;
    assign pop         = id_valid && id_ready && !flush;

    if_id_storage #(
        .DEPTH     (DEPTH),
        .NOP_INSTR (NOP_INSTR)
    ) u_storage (
        .clk   (clk),
        .reset (reset),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ('{pc: fetch_pc, instr: fetch_instr}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Empty queue presents a NOP at pc 0 so decode sees a harmless bubble
    assign id_pc       = id_valid ? head.pc    : '0;
    assign id_instr    = id_valid ? head.instr : NOP_INSTR;
    assign id_pc_plus4 = id_pc + PC_STEP;
    assign occupancy   = count;

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - randomized self-checking bench for if_id_queue against a queue model
module tb_if_id_queue;
    import if_id_queue_pkg::*;

    localparam int DEPTH = 2;
    localparam int OW = $clog2(DEPTH) + 1;
    localparam int VW = 1 + 32 + 32 + 32 + OW + 1;
    localparam logic [31:0] NOP = NOP_INSTR_DEFAULT;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          fetch_valid = 1'b0;
    logic [31:0]   fetch_pc = '0;
    logic [31:0]   fetch_instr = '0;
    logic          fetch_ready;
    logic          flush = 1'b0;
    logic          id_valid;
    logic [31:0]   id_pc;
    logic [31:0]   id_pc_plus4;
    logic [31:0]   id_instr;
    logic          id_ready = 1'b0;
    logic [OW-1:0] occupancy;

    int checks = 0;
    int failures = 0;
    entry_t model[$];
    logic [VW-1:0] obs_vec;

    always #5 clk = ~clk;

    if_id_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_valid (fetch_valid),
        .fetch_pc    (fetch_pc),
        .fetch_instr (fetch_instr),
        .fetch_ready (fetch_ready),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_pc_plus4 (id_pc_plus4),
        .id_instr    (id_instr),
        .id_ready    (id_ready),
        .occupancy   (occupancy)
    );

    assign obs_vec = {id_valid, id_pc, id_pc_plus4, id_instr, occupancy, fetch_ready};

    function automatic logic [VW-1:0] exp_vec();
        logic [31:0] pc;
        logic [31:0] instr;
        pc    = (model.size() != 0) ? model[0].pc : 32'h0;
        instr = (model.size() != 0) ? model[0].instr : NOP;
        return {model.size() != 0, pc, pc + 32'd4, instr, OW'(model.size()), model.size() < DEPTH};
    endfunction

    task automatic tick();
        bit do_push;
        bit do_pop;
        @(posedge clk);
        do_pop  = (model.size() != 0) && id_ready && !flush;
        do_push = fetch_valid && (model.size() < DEPTH) && !flush;
        if (!reset || flush) begin
            model.delete();
        end else begin
            if (do_pop) model.delete(0);
            if (do_push) model.push_back('{pc: fetch_pc, instr: fetch_instr});
        end
        #1;
    endtask

    task automatic drive_idle();
        reset = 1'b1; flush = 1'b0; fetch_valid = 1'b0; id_ready = 1'b0;
    endtask

    task automatic clear_state();
        reset = 1'b0;
        tick();
        drive_idle();
    endtask

    task automatic test_reset();
        reset = 1'b0; fetch_valid = 1'b1; fetch_pc = 32'h40; fetch_instr = $urandom; id_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (obs_vec !== exp_vec()) begin
            failures++; $display("FAIL reset_state obs=%h exp=%h", obs_vec, exp_vec());
        end
        checks++;
        if (id_pc_plus4 !== 32'd4 || id_instr !== NOP || occupancy !== '0 || fetch_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_outputs plus4=%h instr=%h occ=%0d rdy=%b want 4/%h/0/1", id_pc_plus4, id_instr, occupancy, fetch_ready, NOP);
        end
        drive_idle();
    endtask

    task automatic test_streaming();
        logic [31:0] instrs [3];
        clear_state();
        id_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instrs[i] = $urandom;
            fetch_valid = 1'b1; fetch_pc = 32'(i * 4); fetch_instr = instrs[i];
            tick();
            checks++;
            if (obs_vec !== exp_vec() || id_pc !== 32'(i * 4) || id_instr !== instrs[i] || occupancy > 1) begin
                failures++;
                $display("FAIL streaming[%0d] obs=%h exp=%h pc=%h want %h", i, obs_vec, exp_vec(), id_pc, 32'(i * 4));
            end
        end
        fetch_valid = 1'b0;
        tick();
        checks++;
        if (obs_vec !== exp_vec() || id_valid !== 1'b0) begin
            failures++; $display("FAIL streaming_drain obs=%h exp=%h", obs_vec, exp_vec());
        end
    endtask

    task automatic test_stall_full();
        logic [31:0] want_pc [3];
        want_pc = '{32'h10, 32'h14, 32'h18};
        clear_state();
        for (int i = 0; i < 2; i++) begin
            fetch_valid = 1'b1; fetch_pc = want_pc[i]; fetch_instr = $urandom;
            tick();
        end
        fetch_pc = 32'h18; fetch_instr = $urandom;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs_vec !== exp_vec() || occupancy !== OW'(2) || fetch_ready !== 1'b0 || id_pc !== 32'h10) begin
                failures++;
                $display("FAIL stall_full[%0d] occ=%0d rdy=%b pc=%h want 2/0/10", i, occupancy, fetch_ready, id_pc);
            end
        end
        id_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_vec !== exp_vec() || id_pc !== want_pc[i] || id_valid !== 1'b1) begin
                failures++;
                $display("FAIL stall_order[%0d] pc=%h want %h obs=%h exp=%h", i, id_pc, want_pc[i], obs_vec, exp_vec());
            end
            tick();
            if (i == 1) fetch_valid = 1'b0;
        end
        checks++;
        if (obs_vec !== exp_vec() || id_valid !== 1'b0) begin
            failures++; $display("FAIL stall_empty obs=%h exp=%h", obs_vec, exp_vec());
        end
        drive_idle();
    endtask

    task automatic test_back_to_back();
        clear_state();
        fetch_valid = 1'b1; fetch_pc = $urandom; fetch_instr = $urandom;
        tick();
        id_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            fetch_pc = $urandom; fetch_instr = $urandom;
            tick();
            checks++;
            if (obs_vec !== exp_vec() || occupancy !== OW'(1) || id_pc !== fetch_pc) begin
                failures++;
                $display("FAIL back_to_back[%0d] occ=%0d pc=%h want 1/%h", i, occupancy, id_pc, fetch_pc);
            end
        end
        drive_idle();
    endtask

    task automatic test_flush();
        clear_state();
        for (int i = 0; i < 2; i++) begin
            fetch_valid = 1'b1; fetch_pc = 32'h100 + 32'(i * 4); fetch_instr = $urandom;
            tick();
        end
        id_ready = 1'b1; fetch_pc = 32'hBAD0; flush = 1'b1;
        tick();
        flush = 1'b0; fetch_valid = 1'b0;
        checks++;
        if (obs_vec !== exp_vec() || id_valid !== 1'b0 || occupancy !== '0) begin
            failures++; $display("FAIL flush obs=%h exp=%h", obs_vec, exp_vec());
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (id_valid !== 1'b0 || id_pc === 32'hBAD0) begin
                failures++; $display("FAIL flush_ghost[%0d] valid=%b pc=%h want 0", i, id_valid, id_pc);
            end
        end
        drive_idle();
    endtask

    task automatic test_mid_reset_and_wrap();
        clear_state();
        for (int i = 0; i < 2; i++) begin
            fetch_valid = 1'b1; fetch_pc = $urandom; fetch_instr = $urandom;
            tick();
        end
        reset = 1'b0; id_ready = 1'b1;
        tick();
        checks++;
        if (obs_vec !== exp_vec() || occupancy !== '0 || id_instr !== NOP) begin
            failures++; $display("FAIL mid_reset obs=%h exp=%h", obs_vec, exp_vec());
        end
        reset = 1'b1; id_ready = 1'b0; fetch_valid = 1'b1; fetch_pc = 32'hFFFF_FFFC;
        tick();
        fetch_valid = 1'b0;
        checks++;
        if (obs_vec !== exp_vec() || id_pc_plus4 !== 32'h0 || id_pc !== 32'hFFFF_FFFC) begin
            failures++; $display("FAIL pc_wrap plus4=%h pc=%h want 0/fffffffc", id_pc_plus4, id_pc);
        end
        drive_idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            reset       = ($urandom_range(0, 39) != 0);
            flush       = ($urandom_range(0, 19) == 0);
            fetch_valid = $urandom_range(0, 1);
            id_ready    = ($urandom_range(0, 2) != 0);
            fetch_pc    = $urandom;
            fetch_instr = $urandom;
            tick();
            checks++;
            if (obs_vec !== exp_vec()) begin
                failures++; $display("FAIL random[%0d] obs=%h exp=%h", i, obs_vec, exp_vec());
            end
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall_full();
        test_back_to_back();
        test_flush();
        test_mid_reset_and_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
